mvu_apb_csr_target: RTL

APB completer on the MVU side of the pito CSR-to-MVU link. It receives the APB transfers that the hart's CSR unit issues for CSR numbers 0xF20 and up, and decodes them into a small register bank of MVU command, status, interrupt and config registers. It also generates the MVU start pulse and the `mvu_irq` line that feeds back into the hart's `mip` MVU bit.

---
 rtl/mvu_apb_csr_target.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mvu_apb_csr_target.sv
// MVU-side APB completer for the pito CSR-to-MVU link: decodes CSR-numbered
// APB transfers into the MVU command/status/interrupt/config register bank,
// emits the MVU start pulse and drives the interrupt line into mip.
module mvu_apb_csr_target #(
   parameter logic [11:0] BASE_ADDR   = 12'hF20,
   parameter int          NUM_CFG     = 8,
   parameter int          WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [11:0]           apb_paddr,
   input  logic                  apb_psel,
   input  logic                  apb_penable,
   input  logic                  apb_pwrite,
   input  logic [31:0]           apb_pwdata,
   output logic [31:0]           apb_prdata,
   output logic                  apb_pready,
   output logic                  apb_pslverr,
   output logic [NUM_CFG*32-1:0] cfg_o,
   output logic                  mvu_start_o,
   input  logic                  mvu_busy_i,
   input  logic                  mvu_done_i,
   output logic                  mvu_irq_o
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
   // With no wait states a collapsed psel&penable transfer completes in IDLE.
   localparam bit FAST = (WAIT_STATES == 0);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [11:0] addr_q;
   logic        write_q;
   logic [31:0] wdata_q;

   logic [31:0] cfg_q [NUM_CFG];
   logic        irq_en;
   logic        irq_pend;
   logic        start_err;
   logic        start_q;

   logic [11:0]        eff_addr;
   logic               eff_write;
   logic [31:0]        eff_wdata;
   logic [11:0]        off;
   logic               fast_hit;
   logic               acc_rdy;
   logic               ready;
   logic               complete;
   logic               err;
   logic [31:0]        rdata;
   logic               sel_cmd;
   logic               sel_irq;
   logic [NUM_CFG-1:0] cfg_hit;
   logic               do_write;
   logic               wr_cmd;
   logic               wr_irq;

   // Transfer attributes: live bus in IDLE (fast path), latched copy in ACCESS.
   always_comb begin
      fast_hit  = FAST && (state == IDLE) && apb_psel && apb_penable;
      acc_rdy   = (state == ACCESS) && (cnt == 4'd0) && apb_psel;
      ready     = fast_hit || acc_rdy;
      complete  = fast_hit || (acc_rdy && apb_penable);
      eff_addr  = (state == IDLE) ? apb_paddr  : addr_q;
      eff_write = (state == IDLE) ? apb_pwrite : write_q;
      eff_wdata = (state == IDLE) ? apb_pwdata : wdata_q;
   end

   // Address decode, read mux and error detection.
   always_comb begin
      off     = eff_addr - BASE_ADDR;
      rdata   = 32'd0;
      err     = 1'b1;
      sel_cmd = 1'b0;
      sel_irq = 1'b0;
      cfg_hit = '0;
      if (eff_addr >= BASE_ADDR) begin
         if (off == 12'd0) begin
            sel_cmd = 1'b1;
            err     = 1'b0;
         end else if (off == 12'd1) begin
            // STATUS is read-only; a write is rejected.
            err   = eff_write;
            rdata = {29'd0, start_err, irq_pend, mvu_busy_i};
         end else if (off == 12'd2) begin
            sel_irq = 1'b1;
            err     = 1'b0;
            rdata   = {31'd0, irq_en};
         end
         for (int k = 0; k < NUM_CFG; k++) begin
            if (off == 12'(3 + k)) begin
               cfg_hit[k] = 1'b1;
               err        = 1'b0;
               rdata      = cfg_q[k];
            end
         end
      end
      do_write = complete && eff_write && !err;
      wr_cmd   = do_write && sel_cmd;
      wr_irq   = do_write && sel_irq;
   end

   // Response outputs are only meaningful while pready is high.
   always_comb begin
      apb_pready  = ready;
      apb_pslverr = ready && err;
      apb_prdata  = (ready && !eff_write) ? rdata : 32'd0;
   end

   // Transfer FSM: IDLE accepts SETUP (or a collapsed transfer), ACCESS counts wait states.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (apb_psel && (!apb_penable || !FAST)) begin
                  state <= ACCESS;
                  cnt   <= WAIT_CNT;
               end
            end
            ACCESS: begin
               if (!apb_psel)
                  state <= IDLE;
               else if (cnt != 4'd0)
                  cnt <= cnt - 4'd1;
               else if (apb_penable)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture the transfer attributes when a transfer starts in IDLE.
   always_ff @(posedge clk) begin
      if (state == IDLE && apb_psel) begin
         addr_q  <= apb_paddr;
         write_q <= apb_pwrite;
         wdata_q <= apb_pwdata;
      end
   end

   // Register bank: writes commit on completion; hardware set beats W1C clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_en    <= 1'b0;
         irq_pend  <= 1'b0;
         start_err <= 1'b0;
         start_q   <= 1'b0;
         for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= 32'd0;
      end else begin
         start_q <= wr_cmd && eff_wdata[0] && !mvu_busy_i;
         if (wr_irq)
            irq_en <= eff_wdata[0];
         if (mvu_done_i)
            irq_pend <= 1'b1;
         else if (wr_irq && eff_wdata[1])
            irq_pend <= 1'b0;
         if (wr_cmd && eff_wdata[0] && mvu_busy_i)
            start_err <= 1'b1;
         else if (wr_irq && eff_wdata[2])
            start_err <= 1'b0;
         for (int k = 0; k < NUM_CFG; k++)
            if (do_write && cfg_hit[k]) cfg_q[k] <= eff_wdata;
      end
   end

   // Flatten the config bank onto the output bus.
   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
      assign cfg_o[32*g +: 32] = cfg_q[g];
   end

   assign mvu_start_o = start_q;
   assign mvu_irq_o   = irq_pend & irq_en;

endmodule
